pp_bank_reader: RTL and testbench

Downstream drain stage for the dual-bank ping-pong buffer. It waits for a bank to be flagged full, then reads its bytes in address order over a one-cycle-latency read port. It emits them as a valid/ready byte stream with a last-byte marker and an 8-bit frame checksum. When the frame is consumed it pulses a release for that bank, so the writer side can refill it.

---
 rtl/pp_bank_reader_pkg.sv | 19 +
 rtl/pp_bank_reader_if.sv | 32 +++
 rtl/pp_skid_fifo.sv | 54 +++++
 rtl/pp_bank_reader.sv | 131 +++++++++++++
 tb/tb_pp_bank_reader.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_bank_reader_pkg.sv
// Shared definitions for the ping-pong bank reader: FSM encoding, buffer
// geometry defaults and a small bank-select helper.
package pp_bank_reader_pkg;

    localparam int BANK_DEPTH = 128;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [1:0] bank_onehot(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pp_bank_reader_if.sv
// Bus bundle between the bank reader, the ping-pong buffer read port and the
// downstream byte consumer.
interface pp_bank_reader_if #(
    parameter int ADDR_W = pp_bank_reader_pkg::ADDR_W,
    parameter int DATA_W = pp_bank_reader_pkg::DATA_W
) ();

    logic [1:0]        bank_full;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [1:0]        bank_release;
    logic [DATA_W-1:0] frame_sum;
    logic              frame_done;

    modport master (
        input  bank_full, rd_data, out_ready,
        output rd_en, rd_addr, out_data, out_valid, out_last,
               bank_release, frame_sum, frame_done
    );

    modport slave (
        output bank_full, rd_data, out_ready,
        input  rd_en, rd_addr, out_data, out_valid, out_last,
               bank_release, frame_sum, frame_done
    );

endinterface

// File: rtl/pp_skid_fifo.sv
// Two-entry valid/ready buffer with registered output. The writer is
// credit-controlled by the occupancy count, so no input ready is needed.
module pp_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_data_r;
    logic             head_valid_r;
    logic [WIDTH-1:0] spare_data_r;
    logic             spare_valid_r;
    logic             pop_s;

    assign pop_s     = head_valid_r && out_ready;
    assign out_valid = head_valid_r;
    assign out_data  = head_data_r;
    assign count     = {1'b0, head_valid_r} + {1'b0, spare_valid_r};

    // Head refills from the spare first so byte order is preserved.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            head_data_r   <= {WIDTH{1'b0}};
            head_valid_r  <= 1'b0;
            spare_data_r  <= {WIDTH{1'b0}};
            spare_valid_r <= 1'b0;
        end else if (!head_valid_r || pop_s) begin
            if (spare_valid_r) begin
                head_data_r   <= spare_data_r;
                head_valid_r  <= 1'b1;
                spare_valid_r <= in_valid;
                if (in_valid) begin
                    spare_data_r <= in_data;
                end
            end else begin
                head_valid_r <= in_valid;
                if (in_valid) begin
                    head_data_r <= in_data;
                end
            end
        end else if (in_valid) begin
            spare_valid_r <= 1'b1;
            spare_data_r  <= in_data;
        end
    end

endmodule

// File: rtl/pp_bank_reader.sv
// Drains full ping-pong banks in alternating order into a valid/ready byte
// stream, with a per-frame mod-256 checksum and a bank release pulse.
module pp_bank_reader
    import pp_bank_reader_pkg::*;
#(
    parameter int BANK_DEPTH = pp_bank_reader_pkg::BANK_DEPTH,
    parameter int ADDR_W     = pp_bank_reader_pkg::ADDR_W,
    parameter int DATA_W     = pp_bank_reader_pkg::DATA_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    pp_bank_reader_if.master bus
);

    localparam int                OFF_W    = ADDR_W - 1;
    localparam logic [OFF_W-1:0]  LAST_OFF = OFF_W'(BANK_DEPTH - 1);

    state_e            state_r;
    state_e            state_s;
    logic              cur_bank_r;
    logic [OFF_W-1:0]  offset_r;
    logic [DATA_W-1:0] sum_r;
    logic              inflight_r;
    logic              inflight_last_r;

    logic [1:0]        occ_s;
    logic              skid_valid_s;
    logic [DATA_W:0]   skid_data_s;
    logic              pop_s;
    logic              rd_en_s;
    logic              last_rd_s;
    logic              done_s;
    logic [2:0]        need_s;
    logic [2:0]        cap_s;

    pp_skid_fifo #(
        .WIDTH(DATA_W + 1)
    ) u_skid (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (inflight_r),
        .in_data   ({inflight_last_r, bus.rd_data}),
        .out_ready (bus.out_ready),
        .out_valid (skid_valid_s),
        .out_data  (skid_data_s),
        .count     (occ_s)
    );

    // Next state and read strobe; a byte leaving this cycle frees its slot
    // immediately so a full-rate stream never bubbles.
    always_comb begin
        pop_s     = skid_valid_s && bus.out_ready;
        need_s    = {1'b0, occ_s} + {2'b00, inflight_r};
        cap_s     = 3'd2 + {2'b00, pop_s};
        state_s   = state_r;
        rd_en_s   = 1'b0;
        last_rd_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.bank_full[cur_bank_r]) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                rd_en_s   = (need_s < cap_s);
                last_rd_s = rd_en_s && (offset_r == LAST_OFF);
                if (last_rd_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                done_s = pop_s && skid_data_s[DATA_W];
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, offset counter, bank pointer, in-flight tracking and checksum.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r         <= ST_IDLE;
            cur_bank_r      <= 1'b0;
            offset_r        <= {OFF_W{1'b0}};
            sum_r           <= {DATA_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            state_r         <= state_s;
            inflight_r      <= rd_en_s;
            inflight_last_r <= last_rd_s;
            if (state_r == ST_IDLE) begin
                offset_r <= {OFF_W{1'b0}};
                sum_r    <= {DATA_W{1'b0}};
            end else begin
                if (rd_en_s) begin
                    offset_r <= offset_r + OFF_W'(1);
                end
                if (done_s) begin
                    sum_r <= {DATA_W{1'b0}};
                end else if (pop_s) begin
                    sum_r <= sum_r + skid_data_s[DATA_W-1:0];
                end
            end
            if (done_s) begin
                cur_bank_r <= ~cur_bank_r;
            end
        end
    end

    assign bus.rd_en        = rd_en_s;
    assign bus.rd_addr      = {cur_bank_r, offset_r};
    assign bus.out_data     = skid_data_s[DATA_W-1:0];
    assign bus.out_valid    = skid_valid_s;
    assign bus.out_last     = skid_valid_s && skid_data_s[DATA_W];
    assign bus.frame_done   = done_s;
    assign bus.bank_release = done_s ? bank_onehot(cur_bank_r) : 2'b00;
    assign bus.frame_sum    = done_s ? (sum_r + skid_data_s[DATA_W-1:0]) : {DATA_W{1'b0}};

endmodule

// File: tb/tb_pp_bank_reader.sv
// Self-checking bench for pp_bank_reader: a transaction-level model of reads,
// byte arrival and consumption is compared every cycle, plus literal checks.
module tb_pp_bank_reader;
    import pp_bank_reader_pkg::*;

    localparam int BD = 128;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    pp_bank_reader_if bus ();

    pp_bank_reader dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    logic [7:0] mem [256];
    int   tot = 0;
    int   bad = 0;
    int   ncyc = 0;
    logic drv_rst_n;
    logic drv_ready;
    logic rnd_ready;
    logic [1:0] drv_full;

    // Buffer read port with one cycle of latency.
    always @(posedge sys_clk) begin
        if (bus.rd_en === 1'b1) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    // Model: a read issued in cycle c shows at the stream head in cycle c+2
    // at the earliest; at most two bytes may be outstanding after a pop.
    int  q_addr [$];
    int  q_cyc  [$];
    int  cyc = 0;
    bit  m_active = 1'b0;
    int  m_cur = 0;
    int  m_left = 0;
    int  m_off = 0;
    int  m_sum = 0;

    always @(negedge sys_clk) begin : compare
        int outst, hb, exp_addr;
        bit vis, pop, exp_rd, last, done, idle_now;
        #1;
        cyc++;
        vis = 1'b0;
        if (q_addr.size() > 0) vis = (q_cyc[0] + 2 <= cyc);
        pop      = vis && (bus.out_ready === 1'b1);
        outst    = q_addr.size();
        exp_rd   = m_active && (m_left > 0) && ((outst - (pop ? 1 : 0)) < 2);
        exp_addr = m_cur * BD + m_off;
        chk("rd_en", bus.rd_en, exp_rd);
        if (exp_rd) chk("rd_addr", bus.rd_addr, exp_addr);
        chk("out_valid", bus.out_valid, vis);
        hb = 0;
        last = 1'b0;
        if (vis) begin
            hb   = mem[q_addr[0]];
            last = (q_addr[0] % BD) == BD - 1;
            chk("out_data", bus.out_data, hb);
            chk("out_last", bus.out_last, last);
        end
        done = pop && last;
        chk("frame_done", bus.frame_done, done);
        chk("bank_release", bus.bank_release, done ? (m_cur == 1 ? 2 : 1) : 0);
        if (done) chk("frame_sum", bus.frame_sum, (m_sum + hb) % 256);
        idle_now = !m_active;
        if (exp_rd) begin
            q_addr.push_back(exp_addr);
            q_cyc.push_back(cyc);
            m_left--;
            m_off++;
        end
        if (pop) begin
            m_sum = (m_sum + hb) % 256;
            void'(q_addr.pop_front());
            void'(q_cyc.pop_front());
        end
        if (done) begin
            m_active = 1'b0;
            m_cur    = 1 - m_cur;
        end
        if (sys_rst_n === 1'b0) begin
            q_addr.delete();
            q_cyc.delete();
            m_active = 1'b0;
            m_cur    = 0;
            m_sum    = 0;
        end else if (idle_now && bus.bank_full[m_cur] === 1'b1) begin
            m_active = 1'b1;
            m_left   = BD;
            m_off    = 0;
            m_sum    = 0;
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        sys_rst_n     = drv_rst_n;
        bus.bank_full = drv_full;
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : drv_ready;
        #2;
        ncyc++;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rd_en"}, bus.rd_en, 0);
        chk({nm, "_rd_addr"}, bus.rd_addr, 0);
        chk({nm, "_out_data"}, bus.out_data, 0);
        chk({nm, "_out_valid"}, bus.out_valid, 0);
        chk({nm, "_out_last"}, bus.out_last, 0);
        chk({nm, "_release"}, bus.bank_release, 0);
        chk({nm, "_frame_sum"}, bus.frame_sum, 0);
        chk({nm, "_frame_done"}, bus.frame_done, 0);
    endtask

    task automatic do_reset();
        drv_rst_n = 1'b0;
        tick();
        drv_rst_n = 1'b1;
        tick();
        check_zero("reset");
    endtask

    task automatic wait_done(output logic [7:0] s, output logic [1:0] r);
        bit got = 1'b0;
        s = 8'h00;
        r = 2'b00;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            if (bus.frame_done === 1'b1) begin
                got = 1'b1;
                s = bus.frame_sum;
                r = bus.bank_release;
            end
        end
        if (!got) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic wait_rd(input int addr);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            if (bus.rd_en === 1'b1 && bus.rd_addr == addr[7:0]) got = 1'b1;
        end
        if (!got) chk("wait_rd_timeout", 0, 1);
    endtask

    task automatic wait_first_rd();
        bit got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.rd_en === 1'b1) got = 1'b1;
        end
        if (!got) chk("first_rd_timeout", 0, 1);
    endtask

    initial begin : stim
        logic [7:0] s;
        logic [1:0] r;
        int first_cyc, busy, exp_sum;
        sys_rst_n     = 1'b0;
        bus.bank_full = 2'b00;
        bus.out_ready = 1'b0;
        drv_rst_n = 1'b0;
        drv_full  = 2'b00;
        drv_ready = 1'b1;
        rnd_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        tick();
        tick();
        drv_rst_n = 1'b1;
        tick();
        check_zero("por");

        // Bank 0 alone, full rate; latency and frame length pinned.
        drv_full = 2'b01;
        tick();
        chk("lat_idle_rd_en", bus.rd_en, 0);
        tick();
        chk("lat_first_rd_en", bus.rd_en, 1);
        chk("lat_first_addr", bus.rd_addr, 8'h00);
        first_cyc = ncyc;
        tick();
        chk("lat_valid_early", bus.out_valid, 0);
        tick();
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_first_byte", bus.out_data, 8'h00);
        wait_done(s, r);
        chk("b0_sum", s, 8'hC0);
        chk("b0_release", r, 2'b01);
        chk("b0_frame_len", ncyc - first_cyc, BD + 1);
        drv_full = 2'b00;

        // Both banks full: bank 0 then bank 1, one IDLE cycle between.
        do_reset();
        drv_full = 2'b11;
        wait_done(s, r);
        chk("both_b0_release", r, 2'b01);
        chk("both_b0_sum", s, 8'hC0);
        tick();
        chk("gap_idle_rd_en", bus.rd_en, 0);
        tick();
        chk("gap_rd_en", bus.rd_en, 1);
        chk("gap_rd_addr", bus.rd_addr, 8'h80);
        wait_done(s, r);
        chk("both_b1_release", r, 2'b10);
        // 0x80..0xFF sums to 0x5FC0, leaving 0xC0 in the low byte.
        chk("both_b1_sum", s, 8'hC0);
        drv_full = 2'b00;

        // Only bank 1 full: nothing happens until bank 0 is full.
        do_reset();
        drv_full = 2'b10;
        busy = 0;
        repeat (20) begin
            tick();
            if (bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) busy++;
        end
        chk("b1_only_quiet", busy, 0);
        drv_full = 2'b11;
        wait_first_rd();
        chk("b1_only_first_addr", bus.rd_addr, 8'h00);
        wait_done(s, r);
        chk("b1_only_rel0", r, 2'b01);
        wait_done(s, r);
        chk("b1_only_rel1", r, 2'b10);
        drv_full = 2'b00;

        // Reset mid-frame at offset 40; the frame restarts from address 0.
        do_reset();
        drv_full = 2'b01;
        wait_rd(40);
        drv_rst_n = 1'b0;
        tick();
        drv_rst_n = 1'b1;
        tick();
        check_zero("midrst");
        wait_first_rd();
        chk("midrst_restart_addr", bus.rd_addr, 8'h00);
        wait_done(s, r);
        chk("midrst_release", r, 2'b01);
        chk("midrst_sum", s, 8'hC0);
        drv_full = 2'b00;

        // Last byte held for 5 cycles by the consumer.
        do_reset();
        drv_full = 2'b01;
        wait_rd(127);
        drv_full = 2'b00;
        tick();
        drv_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_last", bus.out_last, 1);
            chk("stall_data", bus.out_data, 8'h7F);
            chk("stall_done", bus.frame_done, 0);
            chk("stall_release", bus.bank_release, 0);
        end
        drv_ready = 1'b1;
        tick();
        chk("stall_end_done", bus.frame_done, 1);
        chk("stall_end_release", bus.bank_release, 2'b01);
        chk("stall_end_sum", bus.frame_sum, 8'hC0);
        tick();
        chk("stall_after_done", bus.frame_done, 0);
        chk("stall_after_release", bus.bank_release, 0);

        // Random data with random backpressure, then random bank_full.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        exp_sum = 0;
        for (int i = 0; i < BD; i++) exp_sum = exp_sum + mem[i];
        do_reset();
        rnd_ready = 1'b1;
        drv_full  = 2'b11;
        wait_done(s, r);
        chk("rnd_b0_release", r, 2'b01);
        chk("rnd_b0_sum", s, exp_sum % 256);
        wait_done(s, r);
        chk("rnd_b1_release", r, 2'b10);
        repeat (25) begin
            drv_full = 2'($urandom_range(0, 3));
            repeat (60) tick();
        end
        rnd_ready = 1'b0;
        drv_full  = 2'b00;
        repeat (300) tick();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
